// File: rtl/lsu_ctrl.sv
// Load/store unit controller: turns byte/half/word requests into one or two
// aligned word beats on a synchronous memory port, with load extension.
module lsu_ctrl #(
   parameter bit SPLIT_EN = 1'b1
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_req,
   input  logic [2:0]  i_lsu_sel,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   output logic        o_ready,
   output logic        o_done,
   output logic [31:0] o_rdata,
   output logic        o_misaligned,
   output logic        o_mem_req,
   output logic        o_mem_we,
   output logic [31:0] o_mem_addr,
   output logic [3:0]  o_mem_be,
   output logic [31:0] o_mem_wdata,
   input  logic [31:0] i_mem_rdata
);

   typedef enum logic [2:0] {
      IDLE,
      ACC0,
      ACC1,
      WAIT,
      RESP
   } state_t;

   typedef enum logic [2:0] {
      OP_LW  = 3'b000,
      OP_SW  = 3'b001,
      OP_LB  = 3'b010,
      OP_LBU = 3'b011,
      OP_LH  = 3'b100,
      OP_LHU = 3'b101,
      OP_SB  = 3'b110,
      OP_SH  = 3'b111
   } op_t;

   state_t      state_q, state_d;
   op_t         op_q, op_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] word0_q, word0_d;
   logic [31:0] rdata_q, rdata_d;

   logic [1:0]  off;
   logic        is_byte, is_half, is_store, split;
   logic [3:0]  mask4;
   logic [7:0]  be64;
   logic [63:0] wd64;
   logic [31:0] ld_lo, ld_hi, ld_raw, ld_ext;
   logic        beat, beat_hi;

   always_comb begin
      off      = SPLIT_EN ? addr_q[1:0] : 2'b00;
      is_byte  = (op_q == OP_LB) || (op_q == OP_LBU) || (op_q == OP_SB);
      is_half  = (op_q == OP_LH) || (op_q == OP_LHU) || (op_q == OP_SH);
      is_store = (op_q == OP_SW) || (op_q == OP_SB) || (op_q == OP_SH);
      split    = SPLIT_EN && ((is_half && (off == 2'b11)) ||
                              (!is_byte && !is_half && (off != 2'b00)));
      mask4    = is_byte ? 4'b0001 : (is_half ? 4'b0011 : 4'b1111);
      be64     = {4'b0000, mask4} << off;
      wd64     = {32'h0, wdata_q} << {off, 3'b000};

      // Split loads hold word0 from ACC1; the second word arrives in WAIT.
      ld_lo    = split ? word0_q : i_mem_rdata;
      ld_hi    = split ? i_mem_rdata : '0;
      ld_raw   = 32'({ld_hi, ld_lo} >> {off, 3'b000});
      case (op_q)
         OP_LB:   ld_ext = {{24{ld_raw[7]}}, ld_raw[7:0]};
         OP_LBU:  ld_ext = {24'h0, ld_raw[7:0]};
         OP_LH:   ld_ext = {{16{ld_raw[15]}}, ld_raw[15:0]};
         OP_LHU:  ld_ext = {16'h0, ld_raw[15:0]};
         default: ld_ext = ld_raw;
      endcase
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      word0_d = word0_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: begin
            if (i_req) begin
               op_d    = op_t'(i_lsu_sel);
               addr_d  = SPLIT_EN ? i_addr : {i_addr[31:2], 2'b00};
               wdata_d = i_wdata;
               state_d = ACC0;
            end
         end
         ACC0: begin
            if (split) begin
               state_d = ACC1;
            end else if (is_store) begin
               rdata_d = '0;
               state_d = RESP;
            end else begin
               state_d = WAIT;
            end
         end
         ACC1: begin
            if (is_store) begin
               rdata_d = '0;
               state_d = RESP;
            end else begin
               word0_d = i_mem_rdata;
               state_d = WAIT;
            end
         end
         WAIT: begin
            rdata_d = ld_ext;
            state_d = RESP;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= IDLE;
         op_q    <= OP_LW;
         addr_q  <= '0;
         wdata_q <= '0;
         word0_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         word0_q <= word0_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      beat         = (state_q == ACC0) || (state_q == ACC1);
      beat_hi      = (state_q == ACC1);
      o_ready      = (state_q == IDLE);
      o_done       = (state_q == RESP);
      o_misaligned = (state_q == RESP) && split;
      o_rdata      = rdata_q;
      o_mem_req    = beat;
      o_mem_we     = beat && is_store;
      o_mem_addr   = '0;
      o_mem_be     = '0;
      o_mem_wdata  = '0;
      if (beat) begin
         o_mem_addr  = {addr_q[31:2], 2'b00} + (beat_hi ? 32'd4 : 32'd0);
         o_mem_be    = beat_hi ? be64[7:4] : be64[3:0];
         o_mem_wdata = beat_hi ? wd64[63:32] : wd64[31:0];
      end
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: byte-level memory reference model predicts
// memory beats and responses; a negedge monitor compares them as they appear.
module tb_lsu_ctrl;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_req = 1'b0;
   logic [2:0]  i_lsu_sel = '0;
   logic [31:0] i_addr = '0;
   logic [31:0] i_wdata = '0;
   logic [31:0] i_mem_rdata = '0;
   logic        o_ready, o_done, o_misaligned;
   logic [31:0] o_rdata;
   logic        o_mem_req, o_mem_we;
   logic [31:0] o_mem_addr, o_mem_wdata;
   logic [3:0]  o_mem_be;

   lsu_ctrl #(.SPLIT_EN(1'b1)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_lsu_sel(i_lsu_sel),
      .i_addr(i_addr), .i_wdata(i_wdata), .o_ready(o_ready), .o_done(o_done),
      .o_rdata(o_rdata), .o_misaligned(o_misaligned), .o_mem_req(o_mem_req),
      .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_be(o_mem_be),
      .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
   } beat_t;

   typedef struct {
      logic [31:0] rdata;
      logic        mis;
      int          lat;
   } resp_t;

   beat_t       beat_q[$];
   resp_t       resp_q[$];
   logic [7:0]  ref_mem [logic [31:0]];
   logic [31:0] dmem [256];
   int          n_tests = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          acc_neg = 0;
   logic [31:0] last_rdata = '0;

   // Background contents depend only on addr[31] and addr[8:0], matching dmem indexing.
   function automatic logic [7:0] fill(input logic [31:0] a);
      logic [8:0] lo;
      lo = a[8:0] * 9'd7;
      return lo[7:0] ^ (a[31] ? 8'h3C : 8'h00) ^ 8'h5A;
   endfunction

   function automatic logic [7:0] didx(input logic [31:0] a);
      return {a[31], a[8:2]};
   endfunction

   function automatic logic [7:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : fill(a);
   endfunction

   function automatic logic [31:0] lane_mask(input logic [3:0] be);
      return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   initial begin
      for (int unsigned j = 0; j < 256; j++) begin
         logic [31:0] a;
         a = {j[7], 22'h0, j[6:0], 2'b00};
         dmem[j] = {fill(a | 32'd3), fill(a | 32'd2), fill(a | 32'd1), fill(a)};
      end
   end

   always @(posedge i_clk) begin
      if (o_mem_req) begin
         if (o_mem_we)
            dmem[didx(o_mem_addr)] <= (dmem[didx(o_mem_addr)] & ~lane_mask(o_mem_be)) |
                                      (o_mem_wdata & lane_mask(o_mem_be));
         else
            i_mem_rdata <= dmem[didx(o_mem_addr)];
      end
   end

   initial begin
      beat_t b;
      resp_t r;
      forever begin
         @(negedge i_clk);
         cyc++;
         if (o_ready && i_req && !i_rst) acc_neg = cyc;
         if (o_mem_req) begin
            if (beat_q.size() == 0) begin
               chk("unexpected_beat", o_mem_addr, 32'hDEAD_BEEF);
            end else begin
               b = beat_q.pop_front();
               chk("beat_addr", o_mem_addr, b.addr);
               chk("beat_we", 32'(o_mem_we), 32'(b.we));
               if (b.we) begin
                  chk("beat_be", 32'(o_mem_be), 32'(b.be));
                  chk("beat_wdata", o_mem_wdata & lane_mask(b.be), b.wdata);
               end
            end
         end else begin
            chk("idle_be_we", {27'h0, o_mem_we, o_mem_be}, 32'h0);
         end
         if (o_done) begin
            if (resp_q.size() == 0) begin
               chk("unexpected_done", o_rdata, 32'hDEAD_BEEF);
            end else begin
               r = resp_q.pop_front();
               chk("rdata", o_rdata, r.rdata);
               chk("misaligned", 32'(o_misaligned), 32'(r.mis));
               chk("latency", cyc - acc_neg, r.lat);
            end
            last_rdata = o_rdata;
         end
      end
   end

   task automatic issue(input logic [2:0] sel, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit pulse, input bit rst_mid);
      int          n, k, lane;
      bit          st, split;
      logic [31:0] w0, ba, v;
      beat_t       bt[2];
      resp_t       rs;
      n     = (sel == 3'd0 || sel == 3'd1) ? 4 : ((sel == 3'd2 || sel == 3'd3 || sel == 3'd6) ? 1 : 2);
      st    = (sel == 3'd1 || sel == 3'd6 || sel == 3'd7);
      split = (int'(addr[1:0]) + n) > 4;
      w0    = addr & ~32'd3;
      for (int i = 0; i < 2; i++) begin
         bt[i].addr  = w0 + 32'(4 * i);
         bt[i].we    = st;
         bt[i].be    = '0;
         bt[i].wdata = '0;
      end
      v = '0;
      for (int i = 0; i < n; i++) begin
         ba   = addr + 32'(i);
         k    = ((ba & ~32'd3) != w0) ? 1 : 0;
         lane = int'(ba[1:0]);
         bt[k].be[lane] = 1'b1;
         bt[k].wdata[8*lane +: 8] = wdata[8*i +: 8];
         v[8*i +: 8] = ref_rd(ba);
         if (st && !(rst_mid && k == 1)) ref_mem[ba] = wdata[8*i +: 8];
      end
      if (sel == 3'd2) v = {{24{v[7]}}, v[7:0]};
      if (sel == 3'd4) v = {{16{v[15]}}, v[15:0]};
      beat_q.push_back(bt[0]);
      if (split && !rst_mid) beat_q.push_back(bt[1]);
      rs.rdata = st ? 32'h0 : v;
      rs.mis   = split;
      rs.lat   = st ? (split ? 3 : 2) : (split ? 4 : 3);
      if (!rst_mid) resp_q.push_back(rs);

      for (int t = 0; t < 30 && !o_ready; t++) begin
         @(posedge i_clk); #1;
      end
      if (!o_ready) chk("ready_timeout", 32'(o_ready), 32'd1);
      i_req = 1'b1; i_lsu_sel = sel; i_addr = addr; i_wdata = wdata;
      @(posedge i_clk); #1;
      i_req = 1'b0;
      if (pulse) begin
         @(posedge i_clk); #1;
         i_req = 1'b1; i_lsu_sel = 3'd1; i_addr = 32'h0000_0100; i_wdata = 32'hFFFF_FFFF;
         @(posedge i_clk); #1;
         i_req = 1'b0;
      end
      if (rst_mid) begin
         @(posedge i_clk); #1;
         i_rst = 1'b1;
         #1;
         chk("rst_mem_req", 32'(o_mem_req), 32'd0);
         chk("rst_mem_we", 32'(o_mem_we), 32'd0);
         chk("rst_ready", 32'(o_ready), 32'd1);
         chk("rst_done", 32'(o_done), 32'd0);
         chk("rst_rdata", o_rdata, 32'd0);
         @(posedge i_clk); #1;
         i_rst = 1'b0;
         repeat (4) @(posedge i_clk);
         #1;
      end else begin
         for (int t = 0; t < 20; t++) begin
            @(posedge i_clk); #1;
            if (o_ready) break;
         end
         if (!o_ready) chk("done_timeout", 32'(o_ready), 32'd1);
      end
   endtask

   initial begin
      logic [2:0]  sel;
      logic [31:0] addr;
      #2;
      chk("reset_ready", 32'(o_ready), 32'd1);
      chk("reset_outs", {29'h0, o_done, o_misaligned, o_mem_req}, 32'h0);
      chk("reset_rdata", o_rdata, 32'h0);
      chk("reset_mem_addr", o_mem_addr, 32'h0);
      repeat (2) @(posedge i_clk);
      #1 i_rst = 1'b0;

      issue(3'd1, 32'h0000_0100, 32'h1234_5678, 0, 0);
      issue(3'd1, 32'h0000_0100, 32'h80AA_BBCC, 0, 0);
      issue(3'd2, 32'h0000_0103, 32'h0, 0, 0);
      chk("lb_sign", last_rdata, 32'hFFFF_FF80);
      issue(3'd3, 32'h0000_0103, 32'h0, 0, 0);
      chk("lbu_zero", last_rdata, 32'h0000_0080);
      issue(3'd1, 32'h0000_0100, 32'hDDCC_BBAA, 0, 0);
      issue(3'd1, 32'h0000_0104, 32'h4433_2211, 0, 0);
      issue(3'd0, 32'h0000_0102, 32'h0, 0, 0);
      chk("lw_split", last_rdata, 32'h2211_DDCC);
      issue(3'd7, 32'h0000_00FF, 32'h0000_BEEF, 0, 0);
      issue(3'd0, 32'hFFFF_FFFE, 32'h0, 1, 0);
      issue(3'd1, 32'h0000_0101, 32'hA1B2_C3D4, 0, 1);
      issue(3'd0, 32'h0000_0100, 32'h0, 0, 0);
      issue(3'd0, 32'h0000_0104, 32'h0, 0, 0);

      for (int i = 0; i < 120; i++) begin
         sel = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 7) == 0) addr = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
         else addr = 32'h0000_0100 + 32'($urandom_range(0, 63));
         issue(sel, addr, $urandom, 0, 0);
      end

      repeat (5) @(posedge i_clk);
      #1;
      chk("beat_q_drained", beat_q.size(), 32'd0);
      chk("resp_q_drained", resp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
